// File: rtl/fb_pkg.sv
// fb_pkg: types and defaults shared by the framebuffer display-side blocks
// (line loader, pixel address generator).
//   ld_state_t    : line loader FSM states
//   FB_*_DFLT     : default framebuffer geometry
package fb_pkg;

    localparam int FB_WIDTH_DFLT  = 320;
    localparam int FB_HEIGHT_DFLT = 240;
    localparam int FB_ADDRW_DFLT  = 17;
    localparam int FB_DATAW_DFLT  = 4;
    localparam int FB_RDLAT_DFLT  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } ld_state_t;

endpackage

// File: rtl/fb_line_loader.sv
// fb_line_loader: streams one framebuffer line per linebuffer request out of
// the display-side FB read port, keeping the data valid aligned with the
// BRAM read latency. Tracks line and address counts per frame.
// Ports:
//   clk, rst_n    pixel clock, async active-low reset
//   frame_start   1-cycle pulse at start of vblank; restarts the frame
//   line_req      1-cycle pulse: linebuffer wants the next line
//   fb_addr       FB read address (registered)
//   fb_cidx       FB read data, valid RD_LAT cycles after fb_addr
//   lb_en/lb_cidx linebuffer write strobe and colour index
//   busy          fetch or drain in progress
//   frame_done    all FB_HEIGHT lines issued this frame
//   err_overrun   sticky: line_req arrived while busy
module fb_line_loader
    import fb_pkg::*;
#(
    parameter int FB_WIDTH  = FB_WIDTH_DFLT,
    parameter int FB_HEIGHT = FB_HEIGHT_DFLT,
    parameter int FB_ADDRW  = FB_ADDRW_DFLT,
    parameter int FB_DATAW  = FB_DATAW_DFLT,
    parameter int RD_LAT    = FB_RDLAT_DFLT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start,
    input  logic                line_req,
    output logic [FB_ADDRW-1:0] fb_addr,
    input  logic [FB_DATAW-1:0] fb_cidx,
    output logic                lb_en,
    output logic [FB_DATAW-1:0] lb_cidx,
    output logic                busy,
    output logic                frame_done,
    output logic                err_overrun
);

    localparam int HW = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
    localparam int LW = $clog2(FB_HEIGHT + 1);
    localparam int DW = $clog2(RD_LAT + 1);

    localparam logic [HW-1:0]       H_LAST    = HW'(FB_WIDTH - 1);
    localparam logic [LW-1:0]       LINE_LAST = LW'(FB_HEIGHT - 1);
    localparam logic [DW-1:0]       D_LAST    = DW'(RD_LAT - 1);
    localparam logic [FB_ADDRW-1:0] ADDR_STEP = FB_ADDRW'(FB_WIDTH);

    ld_state_t           state;
    logic [HW-1:0]       h_cnt;
    logic [DW-1:0]       d_cnt;
    logic [LW-1:0]       line_cnt;
    logic [FB_ADDRW-1:0] line_base;
    logic [RD_LAT:1]     vld_pipe;
    logic                issued;

    // Every FETCH cycle presents exactly one new address to the BRAM.
    assign issued = (state == FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            h_cnt       <= '0;
            d_cnt       <= '0;
            line_cnt    <= '0;
            line_base   <= '0;
            fb_addr     <= '0;
            frame_done  <= 1'b0;
            err_overrun <= 1'b0;
        end else if (frame_start) begin
            // Abandons any line in flight; a same-cycle line_req is dropped.
            state       <= IDLE;
            busy        <= 1'b0;
            h_cnt       <= '0;
            d_cnt       <= '0;
            line_cnt    <= '0;
            line_base   <= '0;
            fb_addr     <= '0;
            frame_done  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (line_req && busy)
                err_overrun <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (line_req && !frame_done) begin
                        state   <= FETCH;
                        busy    <= 1'b1;
                        h_cnt   <= '0;
                        fb_addr <= line_base;
                    end
                end
                FETCH: begin
                    if (h_cnt == H_LAST) begin
                        // fb_addr holds on the last pixel so it never runs
                        // past the end of the framebuffer.
                        state     <= DRAIN;
                        d_cnt     <= '0;
                        line_cnt  <= line_cnt + 1'b1;
                        line_base <= line_base + ADDR_STEP;
                        if (line_cnt == LINE_LAST)
                            frame_done <= 1'b1;
                    end else begin
                        h_cnt   <= h_cnt + 1'b1;
                        fb_addr <= fb_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    // Wait out the read latency so busy covers the tail data.
                    if (d_cnt == D_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        d_cnt <= d_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Valid delay line: tail lines up with fb_cidx for the same address;
    // one more register stage gives lb_en/lb_cidx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            lb_en    <= 1'b0;
            lb_cidx  <= '0;
        end else if (frame_start) begin
            vld_pipe <= '0;
            lb_en    <= 1'b0;
        end else begin
            vld_pipe[1] <= issued;
            for (int i = 2; i <= RD_LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];
            lb_en   <= vld_pipe[RD_LAT];
            lb_cidx <= fb_cidx;
        end
    end

endmodule

// File: tb/tb_fb_line_loader.sv
// tb_fb_line_loader: directed bench for fb_line_loader with an 8x4 FB and a
// two-stage BRAM model returning addr[3:0] as data.
module tb_fb_line_loader;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AW = 17;
    localparam int DW = 4;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          line_req = 1'b0;
    logic [AW-1:0] fb_addr;
    logic [DW-1:0] fb_cidx;
    logic          lb_en;
    logic [DW-1:0] lb_cidx;
    logic          busy;
    logic          frame_done;
    logic          err_overrun;

    logic [DW-1:0] bram_q1 = '0;
    logic [DW-1:0] bram_q2 = '0;

    int checks = 0;
    int failures = 0;

    fb_line_loader #(
        .FB_WIDTH (W),
        .FB_HEIGHT(H),
        .FB_ADDRW (AW),
        .FB_DATAW (DW),
        .RD_LAT   (RL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .line_req   (line_req),
        .fb_addr    (fb_addr),
        .fb_cidx    (fb_cidx),
        .lb_en      (lb_en),
        .lb_cidx    (lb_cidx),
        .busy       (busy),
        .frame_done (frame_done),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    // BRAM + retime register: data for an address appears two cycles later.
    always @(posedge clk) begin
        bram_q1 <= fb_addr[3:0];
        bram_q2 <= bram_q1;
    end
    assign fb_cidx = bram_q2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request one line and check cycles t1..t12 after the request cycle:
    // addresses at t1..t8, lb_en at t4..t11, busy through DRAIN (t10).
    // inj_t (>0) re-pulses line_req in that cycle to provoke an overrun.
    task automatic fetch_line(input int base, input int inj_t);
        line_req = 1'b1;
        step();
        line_req = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            chk($sformatf("addr b%0d t%0d", base, t), 32'(fb_addr),
                32'((t <= 8) ? base + t - 1 : base + 7));
            chk($sformatf("lb_en b%0d t%0d", base, t), 32'(lb_en),
                32'((t >= 4 && t <= 11) ? 1 : 0));
            if (t >= 4 && t <= 11)
                chk($sformatf("lb_cidx b%0d t%0d", base, t), 32'(lb_cidx),
                    32'((base + t - 4) & 15));
            chk($sformatf("busy b%0d t%0d", base, t), 32'(busy),
                32'((t <= 10) ? 1 : 0));
            line_req = (t == inj_t);
            step();
        end
        line_req = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst fb_addr", 32'(fb_addr), 32'd0);
        chk("rst lb_en", 32'(lb_en), 32'd0);
        chk("rst lb_cidx", 32'(lb_cidx), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst frame_done", 32'(frame_done), 32'd0);
        chk("rst err", 32'(err_overrun), 32'd0);
        rst_n = 1'b1;
        step();

        // Full frame of four clean lines
        for (int l = 0; l < H; l++) begin
            fetch_line(l * W, 0);
            chk("frame_done mid", 32'(frame_done), 32'((l == H - 1) ? 1 : 0));
        end
        chk("err after frame", 32'(err_overrun), 32'd0);

        // Fifth request after frame_done: ignored, no error
        line_req = 1'b1;
        step();
        line_req = 1'b0;
        for (int t = 0; t < 8; t++) begin
            chk("5th lb_en", 32'(lb_en), 32'd0);
            chk("5th busy", 32'(busy), 32'd0);
            step();
        end
        chk("5th addr hold", 32'(fb_addr), 32'd31);
        chk("5th err", 32'(err_overrun), 32'd0);

        // New frame clears counters
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("fs frame_done", 32'(frame_done), 32'd0);
        chk("fs fb_addr", 32'(fb_addr), 32'd0);

        // Line 0 clean, line 1 with a request during its FETCH
        fetch_line(0, 0);
        chk("no err yet", 32'(err_overrun), 32'd0);
        fetch_line(8, 3);
        chk("overrun err", 32'(err_overrun), 32'd1);

        // Line 2 cut short by frame_start on its 4th lb_en cycle (t7)
        line_req = 1'b1;
        step();
        line_req = 1'b0;
        for (int t = 1; t < 7; t++) step();
        chk("cut lb_en t7", 32'(lb_en), 32'd1);
        chk("cut lb_cidx t7", 32'(lb_cidx), 32'd3);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("cut fb_addr", 32'(fb_addr), 32'd0);
        chk("cut err clr", 32'(err_overrun), 32'd0);
        for (int t = 0; t < 5; t++) begin
            chk("cut lb_en low", 32'(lb_en), 32'd0);
            chk("cut busy low", 32'(busy), 32'd0);
            step();
        end
        fetch_line(0, 0);
        chk("restart err", 32'(err_overrun), 32'd0);

        // frame_start and line_req together: frame_start wins
        frame_start = 1'b1;
        line_req = 1'b1;
        step();
        frame_start = 1'b0;
        line_req = 1'b0;
        for (int t = 0; t < 6; t++) begin
            chk("both busy", 32'(busy), 32'd0);
            chk("both lb_en", 32'(lb_en), 32'd0);
            chk("both fb_addr", 32'(fb_addr), 32'd0);
            step();
        end

        // Async reset in the middle of a fetch
        fetch_line(0, 0);
        line_req = 1'b1;
        step();
        line_req = 1'b0;
        step();
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("arst fb_addr", 32'(fb_addr), 32'd0);
        chk("arst lb_en", 32'(lb_en), 32'd0);
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst frame_done", 32'(frame_done), 32'd0);
        chk("arst err", 32'(err_overrun), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        fetch_line(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case something above stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
